// File: rtl/genius_round_ctrl_if.sv
// Handshake/bus signals between the Genius round controller, the sequence ROM
// and the player panel (buttons + LEDs).
interface genius_round_ctrl_if;
  logic       start;
  logic [1:0] seq_value;
  logic [2:0] btn;
  logic [3:0] seq_index;
  logic [2:0] led;
  logic [4:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  // Environment side: drives start/buttons/ROM data, observes the controller
  modport master (
    output start, seq_value, btn,
    input  seq_index, led, level, busy, win, lose
  );

  // Controller side
  modport slave (
    input  start, seq_value, btn,
    output seq_index, led, level, busy, win, lose
  );
endinterface

// File: rtl/genius_round_ctrl.sv
// Genius (Simon) round controller: plays back the first `level` colours from
// the sequence ROM, then judges the player's presses against the same sequence.
// Optional press timeout enabled by defining GENIUS_TIMEOUT_EN.
module genius_round_ctrl #(
  parameter int unsigned ON_CYCLES      = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20,
  parameter int unsigned MAX_LEN        = 16
) (
  input  logic clk,
  input  logic rst_n,
  genius_round_ctrl_if.slave bus
);

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned LVL_W   = 5;
  localparam int unsigned LED_W   = 3;

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [LVL_W-1:0]   MAX_LVL  = LVL_W'(MAX_LEN);

`ifdef GENIUS_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
`else
  logic [TIMER_W-1:0] timeout_unused;
  assign timeout_unused = TIMER_W'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [2:0] {
    IDLE, SHOW, DARK, PRESS, HOLD, PAUSE, WIN, LOSE
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LED_W-1:0]   held_q, held_d;

  logic [LED_W-1:0]   expected;
  logic [TIMER_W-1:0] timer_inc;
  logic               is_last;

  function automatic logic [LED_W-1:0] onehot(input logic [1:0] v);
    case (v)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  assign expected  = onehot(bus.seq_value);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
  assign is_last   = (LVL_W'(idx_q) + LVL_W'(1)) == level_q;

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      level_q <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      held_q  <= held_d;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    level_d = level_q;
    held_d  = held_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          level_d = LVL_W'(1);
          idx_d   = '0;
          timer_d = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = DARK;
        end else begin
          timer_d = timer_inc;
        end
      end
      DARK: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (is_last) begin
            idx_d   = '0;
            state_d = PRESS;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SHOW;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      PRESS: begin
        if (bus.btn == '0) begin
          timer_d = timer_inc;
`ifdef GENIUS_TIMEOUT_EN
          if (timer_q >= TO_LAST) state_d = LOSE;
`endif
        end else if (bus.seq_value != 2'd3 && bus.btn == expected) begin
          held_d  = bus.btn;
          state_d = HOLD;
        end else begin
          state_d = LOSE;
        end
      end
      HOLD: begin
        if (bus.btn == '0) begin
          if (!is_last) begin
            idx_d   = idx_q + IDX_W'(1);
            timer_d = '0;
            state_d = PRESS;
          end else if (level_q == MAX_LVL) begin
            state_d = WIN;
          end else begin
            level_d = level_q + LVL_W'(1);
            idx_d   = '0;
            timer_d = '0;
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = SHOW;
        end else begin
          timer_d = timer_inc;
        end
      end
      WIN:     state_d = IDLE;
      LOSE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LED decode from registered state
  always_comb begin
    bus.led = '0;
    case (state_q)
      SHOW:    bus.led = expected;
      HOLD:    bus.led = held_q;
      default: bus.led = '0;
    endcase
  end

  assign bus.seq_index = idx_q;
  assign bus.level     = level_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.win       = (state_q == WIN);
  assign bus.lose      = (state_q == LOSE);

endmodule

// File: tb/tb_genius_round_ctrl.sv
// Scoreboard bench for genius_round_ctrl: stimulus pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_genius_round_ctrl;

  localparam int ON  = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  genius_round_ctrl_if bus();

  genius_round_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int rom [16] = '{2, 1, 0, 1, 2, 0, 0, 2, 1, 1, 0, 2, 2, 1, 0, 1};
  assign bus.seq_value = 2'(rom[bus.seq_index]);

  typedef struct {
    string      nm;
    logic [2:0] led;
    logic [3:0] idx;
    logic [4:0] lvl;
    logic       busy;
    logic       win;
    logic       lose;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic int oh(input int v);
    case (v)
      0:       oh = 1;
      1:       oh = 2;
      2:       oh = 4;
      default: oh = 0;
    endcase
  endfunction

  // One clock cycle: record the outputs expected during it, then drive inputs
  task automatic cyc(input int st, input int b, input int e_led, input int e_idx,
                     input int e_lvl, input int e_busy, input int e_win,
                     input int e_lose, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.nm   = nm;
    e.led  = 3'(e_led);
    e.idx  = 4'(e_idx);
    e.lvl  = 5'(e_lvl);
    e.busy = 1'(e_busy);
    e.win  = 1'(e_win);
    e.lose = 1'(e_lose);
    exp_q.push_back(e);
    bus.start = 1'(st);
    bus.btn   = 3'(b);
  endtask

  // Immediate compare of the current DUT outputs
  task automatic check_now(input string nm, input int e_led, input int e_idx,
                           input int e_lvl, input int e_busy, input int e_win,
                           input int e_lose);
    checks++;
    if (bus.led !== 3'(e_led) || bus.seq_index !== 4'(e_idx) || bus.level !== 5'(e_lvl) ||
        bus.busy !== 1'(e_busy) || bus.win !== 1'(e_win) || bus.lose !== 1'(e_lose)) begin
      errors++;
      $display("FAIL %s @%0t: got led=%b idx=%0d lvl=%0d busy=%b win=%b lose=%b, expected led=%b idx=%0d lvl=%0d busy=%b win=%b lose=%b",
               nm, $time, bus.led, bus.seq_index, bus.level, bus.busy, bus.win, bus.lose,
               3'(e_led), e_idx, e_lvl, 1'(e_busy), 1'(e_win), 1'(e_lose));
    end
  endtask

  task automatic play_round(input int lvl, input int st_show);
    for (int i = 0; i < lvl; i++) begin
      for (int c = 0; c < ON; c++)
        cyc((st_show != 0 && i == 0 && c == 0) ? 1 : 0, 0, oh(rom[i]), i, lvl, 1, 0, 0, "show");
      for (int c = 0; c < GAP; c++)
        cyc(0, 0, 0, i, lvl, 1, 0, 0, "dark");
    end
  endtask

  task automatic answer(input int i, input int lvl, input int wait_n, input int hold_n,
                        input int alt);
    for (int w = 0; w < wait_n; w++)
      cyc(0, 0, 0, i, lvl, 1, 0, 0, "press_wait");
    cyc(0, oh(rom[i]), 0, i, lvl, 1, 0, 0, "press");
    for (int h = 0; h < hold_n; h++)
      cyc(0, (h == hold_n - 1) ? 0 : ((alt != 0 && h == 1) ? 3 : oh(rom[i])),
          oh(rom[i]), i, lvl, 1, 0, 0, "hold");
  endtask

  task automatic pause_gap(input int lvl);
    for (int c = 0; c < GAP; c++)
      cyc(0, 0, 0, 0, lvl, 1, 0, 0, "pause");
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (bus.led !== mon_e.led || bus.seq_index !== mon_e.idx || bus.level !== mon_e.lvl ||
          bus.busy !== mon_e.busy || bus.win !== mon_e.win || bus.lose !== mon_e.lose) begin
        errors++;
        $display("FAIL %s @%0t: got led=%b idx=%0d lvl=%0d busy=%b win=%b lose=%b, expected led=%b idx=%0d lvl=%0d busy=%b win=%b lose=%b",
                 mon_e.nm, $time, bus.led, bus.seq_index, bus.level, bus.busy, bus.win, bus.lose,
                 mon_e.led, mon_e.idx, mon_e.lvl, mon_e.busy, mon_e.win, mon_e.lose);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.btn   = 3'b000;

    // Reset held 3 cycles with start high
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    check_now("reset_state", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle_after_reset");

    // Round 1, with a stray second button during the hold, then round 2 playback
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start");
    play_round(1, 0);
    answer(0, 1, 2, 3, 1);
    pause_gap(2);
    play_round(2, 0);

    // Wrong colour on the second press of round 2
    answer(0, 2, 0, 1, 0);
    cyc(0, 1, 0, 1, 2, 1, 0, 0, "press_wrong");
    cyc(0, 0, 0, 1, 2, 1, 0, 1, "lose_wrong");
    cyc(0, 0, 0, 1, 2, 0, 0, 0, "idle_after_lose");

    // Multi-button press in round 1; start during SHOW ignored
    cyc(1, 0, 0, 1, 2, 0, 0, 0, "start_multi");
    play_round(1, 1);
    cyc(0, 5, 0, 0, 1, 1, 0, 0, "press_multi");
    cyc(0, 0, 0, 0, 1, 1, 0, 1, "lose_multi");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, "idle_after_multi");

    // Idle in PRESS
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "start_timeout");
    play_round(1, 0);
`ifdef GENIUS_TIMEOUT_EN
    for (int k = 0; k < 20; k++)
      cyc(0, 0, 0, 0, 1, 1, 0, 0, "press_timeout_wait");
    cyc(0, 0, 0, 0, 1, 1, 0, 1, "lose_timeout");
    check_now("timeout_expired", 0, 0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, "idle_after_timeout");
`else
    for (int k = 0; k < 200; k++)
      cyc(0, 0, 0, 0, 1, 1, 0, 0, "press_no_timeout");
    check_now("no_timeout_wait", 0, 0, 1, 1, 0, 0);
`endif
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset_abort");
    rst_n = 1'b1;

    // Full game to MAX_LEN
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "start_full");
    for (int l = 1; l <= 16; l++) begin
      play_round(l, 0);
      for (int i = 0; i < l; i++) answer(i, l, i % 2, 1 + (i % 3), 0);
      if (l < 16) pause_gap(l + 1);
    end
    cyc(0, 0, 0, 15, 16, 1, 1, 0, "win");
    cyc(0, 0, 0, 15, 16, 0, 0, 0, "idle_after_win");

    // Reset during round 5 playback
    cyc(1, 0, 0, 15, 16, 0, 0, 0, "start_r5");
    for (int l = 1; l <= 4; l++) begin
      play_round(l, 0);
      for (int i = 0; i < l; i++) answer(i, l, 0, 1, 0);
      pause_gap(l + 1);
    end
    cyc(0, 0, oh(rom[0]), 0, 5, 1, 0, 0, "show_r5");
    cyc(0, 0, oh(rom[0]), 0, 5, 1, 0, 0, "show_r5");
    rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset_r5");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle_after_r5");

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/genius_round_ctrl.md
Name: genius_round_ctrl

Overview:
- Round controller for the Genius (Simon) game; sits directly downstream of the colour sequence ROM.
- Drives the ROM index, plays back the first `level` colours on three LEDs, then checks the player's button presses against the same sequence.
- Grows the round by one after every correct round; reports win at length 16 and lose on any error.

Parameters:
- ON_CYCLES, 4, clock cycles a colour LED is lit during playback (>=1).
- GAP_CYCLES, 2, dark cycles after each played colour and between rounds (>=1).
- TIMEOUT_CYCLES, 20, max cycles waiting for a press (TIMEOUT_EN only, >=1).
- MAX_LEN, 16, sequence length needed to win (1..16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  begin new game; sampled only in IDLE.
- seq_value  in  2  colour at seq_index from the sequence ROM (0,1,2; 3 is invalid).
- btn  in  3  player buttons, debounced level, bit k = colour k.
- seq_index  out  4  ROM index.
- led  out  3  one-hot colour LEDs.
- level  out  5  current round length (0 before the first game, then 1..16).
- busy  out  1  high in every state except IDLE.
- win  out  1  one-cycle pulse.
- lose  out  1  one-cycle pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, seq_index=0, level=0, timer=0, win=lose=0. led=000 and busy=0 follow from IDLE. Reset mid-game aborts immediately, with no win or lose pulse.
- seq_value is combinational from seq_index, so it is valid in the same cycle as seq_index.
- onehot(v): 0→001, 1→010, 2→100, 3→000.
- led is decoded from registered state:
  - SHOW: onehot(seq_value).
  - HOLD: the latched pressed button.
  - All other states: 000.
- States:
  - IDLE: start=1 → level=1, seq_index=0, timer=0, go to SHOW. A start asserted in any other state is ignored.
  - SHOW: stays exactly ON_CYCLES cycles, then DARK with timer=0.
  - DARK: stays GAP_CYCLES cycles.
    - If seq_index==level-1: seq_index=0, timer=0, go to PRESS.
    - Otherwise: seq_index+1, go to SHOW.
  - PRESS:
    - btn==000: wait, timer increments.
    - btn==onehot(seq_value) and seq_value!=3: latch btn, go to HOLD.
    - Any other nonzero btn (wrong colour, multiple bits, or seq_value==3): go to LOSE.
  - HOLD: waits until btn==000.
    - If seq_index<level-1: seq_index+1, timer=0, go to PRESS.
    - Else if level==MAX_LEN: go to WIN.
    - Else: level+1, seq_index=0, timer=0, go to PAUSE.
    - A different nonzero btn value while in HOLD is ignored until full release.
  - PAUSE: GAP_CYCLES dark cycles, then SHOW.
  - WIN: win=1 for this single cycle, then IDLE.
  - LOSE: lose=1 for this single cycle, then IDLE.
  - In both WIN and LOSE, level keeps its value until the next start.
- Counters:
  - timer is 32 bits and saturates.
  - seq_index is 4 bits and never exceeds level-1, so no wrap occurs.
  - level is 5 bits and never exceeds MAX_LEN.
- A press held from before PRESS is entered is judged in the first PRESS cycle.

Optional Feature:
- Macro: GENIUS_TIMEOUT_EN.
- Defined: in PRESS, when timer reaches TIMEOUT_CYCLES with btn==000 → LOSE. The timer resets on every entry to PRESS.
- Undefined: no timeout; PRESS waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with start=1 → led=000, seq_index=0, level=0, busy=0, win=lose=0.
- Round 1 (ROM sequence 2,1,0,1,...): pulse start → busy=1, level=1, led=100 for 4 cycles, then 000 for 2 cycles. Then press btn=100 for 3 cycles → led=100 during the hold. Release → 2 dark cycles, level=2, playback led=100 (4 cycles), 000 (2), 010 (4), 000 (2).
- Wrong colour: at round 2, press 100 then release, then press 001 → lose=1 for exactly 1 cycle, busy=0, level stays 2, led=000.
- Multi-press: at round 1, drive btn=101 → lose pulse. A start during SHOW has no effect on level or seq_index.
- Timeout (GENIUS_TIMEOUT_EN defined): enter PRESS and keep btn=000 → lose asserted 20 cycles after PRESS entry. Macro undefined: still in PRESS with busy=1 after 200 cycles.
- Full game (MAX_LEN=16): answer all 16 rounds correctly → win=1 for 1 cycle after the final release, level=16, lose never asserted. Reset asserted mid-playback at round 5 → IDLE next cycle, no win or lose pulse.
